// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// load_store_unit
//
// Requester side of the data-memory interface. Accepts one CPU load/store at
// a time over a valid/ready handshake and turns it into word accesses on an
// async-read / sync-write word memory. Byte and halfword loads are extracted
// and sign/zero extended. SB/SH are done as read-modify-write.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU (addr[0]=1) or W (addr[1:0]!=0) returns an
//               error with no memory access.
//   undefined : low address bits are ignored (force-aligned), no misalign error.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we                  1 = store, 0 = load
//   req_funct3              RV32I width/extension code
//   req_addr, req_wdata     byte address and store data
//   resp_valid/resp_ready   response handshake, response held while stalled
//   resp_rdata, resp_err    extended load data (0 for stores/errors), error flag
//   mem_addr                word-aligned byte address to memory
//   mem_din                 write word
//   mem_read, mem_write     access strobes, never both high
//   mem_dout                memory read word, combinational from mem_addr
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST_RD,
        ST_WR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size of the attached memory in bytes, kept 33 bits wide so that the
    // end of the window never wraps back onto low addresses.
    localparam logic [32:0] MEM_SPAN = 33'(MEM_DEPTH) << 2;

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [32:0] req_offset;
    logic        funct3_ok;
    logic        range_ok;
    logic        misalign;
    logic        req_err;
    logic [31:0] word_addr;

    // Select a byte/halfword lane of a memory word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Overlay the store byte/halfword onto the word read back from memory.
    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  f3,
                                          input logic [31:0] data);
        logic [31:0] r;
        r = word;
        if (f3[1:0] == 2'b00) begin
            r[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return r;
    endfunction

    // Request error check, evaluated on the live request while in IDLE.
    always_comb begin
        // An address below BASE_ADDR borrows into bit 32 of the offset.
        req_offset = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        range_ok   = !req_offset[32] && (req_offset < MEM_SPAN);

        case (req_funct3)
            F3_B, F3_H, F3_W: funct3_ok = 1'b1;
            F3_BU, F3_HU:     funct3_ok = !req_we;
            default:          funct3_ok = 1'b0;
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif

        req_err = !funct3_ok || !range_ok || misalign;
    end

    assign word_addr = {addr_q[31:2], 2'b00};

    // NOTE: state is reset asynchronously so mem_write, decoded from state
    // below, falls the instant reset rises and no partial store can land.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_din    = 32'h0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (!req_we) begin
                        next_state = LD;
                    end else if (req_funct3 == F3_W) begin
                        next_state = ST_WR;
                    end else begin
                        next_state = ST_RD;
                    end
                end
            end
            LD: begin
                mem_read   = 1'b1;
                mem_addr   = word_addr;
                next_state = RESP;
            end
            ST_RD: begin
                mem_read   = 1'b1;
                mem_addr   = word_addr;
                next_state = ST_WR;
            end
            ST_WR: begin
                mem_write  = 1'b1;
                mem_addr   = word_addr;
                mem_din    = (funct3_q == F3_W) ? wdata_q : word_q;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        err_q    <= req_err;
                        rdata_q  <= 32'h0;
                    end
                end
                LD:      rdata_q <= extract(mem_dout, addr_q[1:0], funct3_q);
                ST_RD:   word_q  <= merge(mem_dout, addr_q[1:0], funct3_q, wdata_q);
                default: ;
            endcase
        end
    end

    // Response fields read as zero whenever no response is being presented.
    assign resp_rdata = (state == RESP) ? rdata_q : 32'h0;
    assign resp_err   = (state == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Self-checking bench for load_store_unit: word memory model, request-level
// reference model, per-cycle compare process and directed vectors.
module tb_load_store_unit;

    localparam int          DEPTH = 16384;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int          tests = 0;
    int          fails = 0;

    logic        resp_expected   = 1'b0;
    logic        no_mem_expected = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;
    logic [31:0] got_rdata = 32'h0;
    logic        got_err   = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_dout   (mem_dout)
    );

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return int'(o[13:0]);
    endfunction

    // Attached memory: async read, write on posedge.
    assign mem_dout = mem[widx(mem_addr)];
    always @(posedge clk) if (mem_write) mem[widx(mem_addr)] <= mem_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Request-level reference: error, load value, latency, memory effect.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat);
        longint      off;
        int          size;
        int          idx;
        int          sh;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        err = (size == 0) || (we && f3[2]) || (off < 0) || (off >= 4 * longint'(DEPTH));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00)) err = 1'b1;
`endif
        rd = 32'h0;
        if (err) begin
            lat = 1;
            return;
        end
        off  = off - (off % size);
        idx  = int'(off / 4);
        sh   = int'(off % 4) * 8;
        w    = ref_mem[idx];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((size == 2) ? 32'h0000_FFFF : 32'h0000_00FF);
        if (!we) begin
            v = (w >> sh) & mask;
            if (!f3[2] && size < 4 && v[size*8-1]) v = v | ~mask;
            rd  = v;
            lat = 2;
        end else begin
            ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // Per-cycle compare against the expectations published by the driver.
    always @(negedge clk) begin
        if (!reset) begin
            check("strobes_exclusive", 32'(mem_read && mem_write), 32'h0);
            if (mem_read || mem_write) check("mem_addr_aligned", 32'(mem_addr[1:0]), 32'h0);
            if (no_mem_expected) check("no_mem_strobe_on_err", 32'(mem_read || mem_write), 32'h0);
            if (resp_valid) begin
                check("resp_when_expected", 32'(resp_expected), 32'h1);
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
                check("req_ready_low_in_resp", 32'(req_ready), 32'h0);
                check("mem_idle_in_resp", 32'(mem_read || mem_write), 32'h0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall, input string name);
        logic        e;
        logic [31:0] r;
        int          lat;
        int          seen;
        model(we, f3, a, wd, e, r, lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        check({name, " req_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid       = 1'b0;
        exp_rdata       = r;
        exp_err         = e;
        resp_expected   = 1'b1;
        no_mem_expected = e;
        seen = 0;
        do begin
            @(negedge clk);
            seen++;
        end while (!resp_valid && seen < 8);
        check({name, " latency"}, 32'(seen), 32'(lat));
        got_rdata = resp_rdata;
        got_err   = resp_err;
        repeat (stall) @(negedge clk);
        if (stall > 0) check({name, " rdata_stable"}, resp_rdata, got_rdata);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready      = 1'b0;
        resp_expected   = 1'b0;
        no_mem_expected = 1'b0;
        @(negedge clk);
        check({name, " resp_dropped"}, 32'(resp_valid), 32'h0);
        check({name, " back_to_idle"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int diffs;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'h1);
        check("rst resp_valid", 32'(resp_valid), 32'h0);
        check("rst resp_err", 32'(resp_err), 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst strobes", 32'({mem_read, mem_write}), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_din", mem_din, 32'h0);
        reset = 1'b0;

        // Word and sub-word traffic with hand-computed results.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, "sw_10");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10");
        check("lw_10 literal", got_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 3'b000, 32'h12, 32'h0000_0055, 0, "sb_12");
        check("sb_12 word", mem[4], 32'hDE55_BEEF);
        do_req(1'b0, 3'b000, 32'h12, 32'h0, 0, "lb_12");
        check("lb_12 literal", got_rdata, 32'h0000_0055);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu_13");
        check("lbu_13 literal", got_rdata, 32'h0000_00DE);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 0, "lh_10");
        check("lh_10 literal", got_rdata, 32'hFFFF_BEEF);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 0, "lhu_10");
        check("lhu_10 literal", got_rdata, 32'h0000_BEEF);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234, 0, "sh_12");
        check("sh_12 word", mem[4], 32'h1234_BEEF);

        // Response stall.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, "lw_stall");
        check("lw_stall literal", got_rdata, 32'h1234_BEEF);

        // Sign/zero extension of negative lanes.
        do_req(1'b1, 3'b000, 32'h20, 32'hFFFF_FF80, 0, "sb_20");
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 0, "lb_20");
        check("lb_20 literal", got_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, 0, "lbu_20");
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_8001, 0, "sh_22");
        check("sh_22 word", mem[8], 32'h8001_0080);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 0, "lh_22");
        check("lh_22 literal", got_rdata, 32'hFFFF_8001);

        // Range boundaries and illegal encodings.
        do_req(1'b1, 3'b010, 32'hFFFC, 32'hA5A5_0001, 0, "sw_last");
        do_req(1'b0, 3'b100, 32'hFFFF, 32'h0, 0, "lbu_last");
        check("lbu_last literal", got_rdata, 32'h0000_00A5);
        do_req(1'b0, 3'b010, 32'h1_0000, 32'h0, 0, "lw_oor");
        check("lw_oor err", 32'(got_err), 32'h1);
        do_req(1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0, 0, "lh_top");
        do_req(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1, 0, "sw_top");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, "ld_f3_011");
        check("ld_f3_011 err", 32'(got_err), 32'h1);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 0, "ld_f3_110");
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 0, "st_f3_100");
        do_req(1'b1, 3'b011, 32'h10, 32'h0, 0, "st_f3_011");

        // Misaligned word access.
        do_req(1'b0, 3'b010, 32'h11, 32'h0, 0, "lw_11");
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_11 err", 32'(got_err), 32'h1);
`else
        check("lw_11 literal", got_rdata, 32'h1234_BEEF);
`endif
        do_req(1'b1, 3'b001, 32'h23, 32'h0000_7777, 0, "sh_23");

        // Reset during the write phase of an SB.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h12;
        req_wdata  = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 0;
        do begin
            @(negedge clk);
            seen++;
        end while (!mem_write && seen < 6);
        check("rst_mid st_wr reached", 32'(mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid mem_write drop", 32'(mem_write), 32'h0);
        check("rst_mid idle", 32'(req_ready), 32'h1);
        check("rst_mid no resp", 32'(resp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid word kept", mem[4], 32'h1234_BEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_after_rst");

        // Whole memory against the reference image.
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("memory image", 32'(diffs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
